// File: rtl/fifo_nibble_packer_pkg.sv
// Shared defaults and state encodings for the FIFO word packer.
// Both states and the output width are defined here so every file uses the same values.
package fifo_nibble_packer_pkg;

  localparam int MEMORY_WIDTH_DEF = 4;
  localparam int PACK_FACTOR_DEF  = 4;
  localparam int COUNT_SIZE_DEF   = 3;
  localparam int OUT_WIDTH_DEF    = MEMORY_WIDTH_DEF * PACK_FACTOR_DEF;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  function automatic int out_width(input int memory_width, input int pack_factor);
    return memory_width * pack_factor;
  endfunction

endpackage

// File: rtl/fifo_nibble_packer.sv
// Drains fifo_sync words and packs PACK_FACTOR of them (LSB slot first) into one wide beat.
// A flush emits a partially filled beat; the output stream is valid/ready with full backpressure.
module fifo_nibble_packer
  import fifo_nibble_packer_pkg::*;
#(
  parameter int MEMORY_WIDTH = MEMORY_WIDTH_DEF,
  parameter int PACK_FACTOR  = PACK_FACTOR_DEF,
  parameter int COUNT_SIZE   = COUNT_SIZE_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  EMPTY,
  input  logic [MEMORY_WIDTH-1:0]               RD,
  output logic                                  r_en,
  input  logic                                  flush,
  output logic [MEMORY_WIDTH*PACK_FACTOR-1:0]   out_data,
  output logic [COUNT_SIZE-1:0]                 out_count,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int OUT_WIDTH = out_width(MEMORY_WIDTH, PACK_FACTOR);

  logic [0:0]            state_reg;
  logic [COUNT_SIZE-1:0] cnt_reg;
  logic                  rd_pend_reg;
  logic                  flush_pend_reg;
  logic [OUT_WIDTH-1:0]  acc_reg;

  logic [OUT_WIDTH-1:0]  acc_next;
  logic [COUNT_SIZE-1:0] cnt_next;
  logic [COUNT_SIZE:0]   fill_level;
  logic                  word_full;

  // Words already held plus the one in flight must leave room, so reads never overrun a beat.
  assign fill_level = {1'b0, cnt_reg} + {{COUNT_SIZE{1'b0}}, rd_pend_reg};
  assign r_en = !rst && (state_reg == COLLECT) && !EMPTY && !flush_pend_reg &&
                (fill_level < (COUNT_SIZE+1)'(PACK_FACTOR));

  genvar gi;
  generate
    for (gi = 0; gi < PACK_FACTOR; gi++) begin : g_slot
      assign acc_next[gi*MEMORY_WIDTH +: MEMORY_WIDTH] =
        (rd_pend_reg && (cnt_reg == COUNT_SIZE'(gi))) ? RD
                                                      : acc_reg[gi*MEMORY_WIDTH +: MEMORY_WIDTH];
    end
  endgenerate

  assign cnt_next  = cnt_reg + COUNT_SIZE'(rd_pend_reg);
  assign word_full = (cnt_next == COUNT_SIZE'(PACK_FACTOR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= COLLECT;
      cnt_reg        <= '0;
      rd_pend_reg    <= 1'b0;
      flush_pend_reg <= 1'b0;
      acc_reg        <= '0;
      out_data       <= '0;
      out_count      <= '0;
      out_valid      <= 1'b0;
    end else begin
      rd_pend_reg <= r_en;
      if (state_reg == COLLECT) begin
        if (word_full) begin
          // A flush pending here is kept and later serviced with an empty accumulator.
          out_data       <= acc_next;
          out_count      <= COUNT_SIZE'(PACK_FACTOR);
          out_valid      <= 1'b1;
          cnt_reg        <= '0;
          acc_reg        <= '0;
          state_reg      <= HOLD;
          flush_pend_reg <= flush_pend_reg | flush;
        end else if (flush_pend_reg && !rd_pend_reg) begin
          flush_pend_reg <= 1'b0;
          if (cnt_reg != '0) begin
            out_data  <= acc_reg;
            out_count <= cnt_reg;
            out_valid <= 1'b1;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            state_reg <= HOLD;
          end
        end else begin
          acc_reg        <= acc_next;
          cnt_reg        <= cnt_next;
          flush_pend_reg <= flush_pend_reg | flush;
        end
      end else begin
        flush_pend_reg <= flush_pend_reg | flush;
        if (out_ready) begin
          out_valid <= 1'b0;
          state_reg <= COLLECT;
        end
      end
    end
  end

endmodule
